data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  DATA_WIDTH, 32, word width
  LINE_SIZE, 4, words per line (fixed 4; offset = addr[1:0])
  NUM_LINES, 16, direct-mapped lines (power of 2)
  MEM_LATENCY, 2, cycles refill holds mem_ReadEn before capture (>=1)
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  clk  in  1  single clock, all state on rising edge
  rstn  in  1  asynchronous, active-low reset
  cpu_read  in  1  load request
  cpu_write  in  1  store request
  funct3  in  3  RISC-V load/store funct3
  cpu_addr  in  32  word address
  cpu_wdata  in  32  store data
  cpu_rdata  out  32  load result
  stall  out  1  pipeline hold
  mem_ReadEn  out  1  line-read enable to data memory
  mem_WriteEn  out  1  write-through enable to data memory
  mem_funct3  out  3  store width to data memory
  mem_Addr  out  32  data-memory word address
  mem_WriteData  out  32  store data to data memory
  mem_data  in  LINE_SIZE x DATA_WIDTH  line returned by data memory, element i = word {line,i}
REQ-003 Address split SHALL be: offset = addr[1:0], index = addr[2+log2(NUM_LINES)-1:2], tag = remaining upper bits.

Function
REQ-004 FSM states SHALL be IDLE, REFILL, WRITE.
REQ-005 Read hit in IDLE (valid and tag match): stall=0, cpu_rdata valid combinationally same cycle.
REQ-006 Read miss in IDLE: stall=1, next state REFILL, latency counter cleared.
REQ-007 REFILL: stall=1, mem_ReadEn=1, mem_Addr={cpu_addr[31:2],2'b00}; after exactly MEM_LATENCY cycles capture all mem_data words, set tag and valid, return to IDLE; total read-miss stall = MEM_LATENCY+1 cycles.
REQ-008 Store in IDLE (hit or miss): stall=1, next state WRITE; WRITE asserts mem_WriteEn for exactly one cycle with mem_Addr=cpu_addr, mem_funct3=funct3, mem_WriteData=cpu_wdata, stall=0, then IDLE.
REQ-009 Store policy: write-through, no-allocate; on hit, cached word merged in WRITE: funct3 000 updates [7:0], 001 updates [15:0], else full word.
REQ-010 Load extraction: 000 sign-extend [7:0], 100 zero-extend [7:0], 001 sign-extend [15:0], 101 zero-extend [15:0], 010 full word, other funct3 returns 0.
REQ-011 cpu_read and cpu_write both high: treated as store.
REQ-012 mem_ReadEn=0 outside REFILL; mem_WriteEn=0 outside WRITE; cpu_rdata=0 when no read hit.
REQ-013 Conflict miss overwrites the indexed line unconditionally (no dirty state).

Reset
REQ-014 rstn low SHALL asynchronously force state IDLE, counter 0, all valid bits 0, stall=0, mem_ReadEn=0, mem_WriteEn=0, cpu_rdata=0; data/tag arrays need no reset.
REQ-015 Reset during REFILL or WRITE SHALL abandon the operation with no line marked valid.

Structure
REQ-016 Package dcache_pkg SHALL hold the state enum, funct3 load/store constants and address-field width constants.
REQ-017 One sub-module, dcache_load_align (word + funct3 -> cpu_rdata), SHALL implement REQ-010.

Verification (memory preset: word 7=0xA5214AAB, word 8=25, word 16=11, word 59=0xD494A2FA, word 336=12414)
REQ-018 lw word 7 cold -> stall 3 cycles (MEM_LATENCY=2), mem_Addr=4, then cpu_rdata=0xA5214AAB; repeat lw word 6 -> stall 0, 18.
REQ-019 lb word 7 -> 0xFFFFFFAB; lbu -> 0x000000AB; lh word 59 -> 0xFFFFA2FA; lhu -> 0x0000A2FA.
REQ-020 lw word 16 then lw word 336 (same index 4) -> second misses, returns 12414; lw word 16 again misses, returns 11.
REQ-021 lw word 8, then sb word 8 data 0x123456FF -> one stall cycle, mem_WriteEn one cycle, mem_funct3=000, mem_Addr=8; next lw word 8 hits, returns 0x000000FF.
REQ-022 Assert rstn low during second REFILL cycle of word 40 -> stall and mem_ReadEn drop immediately; after release lw word 40 misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM states, RISC-V load/store funct3 encodings and address-field
// widths shared by the data cache and its load aligner.
package dcache_pkg;
    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;
    localparam int ADDR_W = 32;
    localparam int OFF_W  = 2;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
endpackage

// File: rtl/dcache_load_align.sv
// dcache_load_align: extracts and sign/zero-extends a load result from a cached
// word according to the RISC-V load funct3.
module dcache_load_align import dcache_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    always_comb
        rdata_o = funct3_i == F3_LB  ? {{(DATA_WIDTH-8){word_i[7]}}, word_i[7:0]} :
                  funct3_i == F3_LBU ? {{(DATA_WIDTH-8){1'b0}}, word_i[7:0]} :
                  funct3_i == F3_LH  ? {{(DATA_WIDTH-16){word_i[15]}}, word_i[15:0]} :
                  funct3_i == F3_LHU ? {{(DATA_WIDTH-16){1'b0}}, word_i[15:0]} :
                  funct3_i == F3_LW  ? word_i : '0;
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-allocate data cache with
// fixed-latency line refill and a single-cycle store handshake to data memory.
module data_cache import dcache_pkg::*; #(
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_SIZE   = 4,
    parameter int NUM_LINES   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 cpu_read,
    input  logic                                 cpu_write,
    input  logic [2:0]                           funct3,
    input  logic [ADDR_W-1:0]                    cpu_addr,
    input  logic [DATA_WIDTH-1:0]                cpu_wdata,
    output logic [DATA_WIDTH-1:0]                cpu_rdata,
    output logic                                 stall,
    output logic                                 mem_ReadEn,
    output logic                                 mem_WriteEn,
    output logic [2:0]                           mem_funct3,
    output logic [ADDR_W-1:0]                    mem_Addr,
    output logic [DATA_WIDTH-1:0]                mem_WriteData,
    input  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] mem_data
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int CNT_W = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [NUM_LINES-1:0]                 valid_q;
    logic [TAG_W-1:0]                     tag_q  [NUM_LINES];
    logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] data_q [NUM_LINES];

    logic [OFF_W-1:0]      off;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit, load, refill_done;
    logic [DATA_WIDTH-1:0] cur_word, merged, aligned;

    assign off         = cpu_addr[OFF_W-1:0];
    assign idx         = cpu_addr[OFF_W +: IDX_W];
    assign tag         = cpu_addr[ADDR_W-1 -: TAG_W];
    assign hit         = valid_q[idx] && tag_q[idx] == tag;
    assign load        = cpu_read && !cpu_write;
    assign refill_done = state_q == REFILL && cnt_q == CNT_W'(MEM_LATENCY - 1);
    assign cur_word    = data_q[idx][off];

    always_comb begin
        state_d = state_q == IDLE   ? (cpu_write ? WRITE : (load && !hit) ? REFILL : IDLE) :
                  state_q == REFILL ? (refill_done ? IDLE : REFILL) : IDLE;
        cnt_d   = state_q == REFILL ? cnt_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (refill_done) valid_q[idx] <= 1'b1;
        end

    // Store hits merge only the written bytes so the cached word stays coherent with memory.
    always_comb
        merged = funct3 == F3_SB ? {cur_word[DATA_WIDTH-1:8], cpu_wdata[7:0]} :
                 funct3 == F3_SH ? {cur_word[DATA_WIDTH-1:16], cpu_wdata[15:0]} : cpu_wdata;

    always_ff @(posedge clk)
        if (refill_done) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_data;
        end else if (state_q == WRITE && hit) begin
            data_q[idx][off] <= merged;
        end

    dcache_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word_i   (cur_word),
        .funct3_i (funct3),
        .rdata_o  (aligned)
    );

    // Stall is gated by rstn so a request held during reset cannot stall the pipeline.
    assign stall         = state_q == REFILL ||
                           (rstn && state_q == IDLE && (cpu_write || (load && !hit)));
    assign mem_ReadEn    = state_q == REFILL;
    assign mem_WriteEn   = state_q == WRITE;
    assign mem_funct3    = funct3;
    assign mem_WriteData = cpu_wdata;
    assign mem_Addr      = state_q == REFILL ? {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : cpu_addr;
    assign cpu_rdata     = (state_q == IDLE && load && hit) ? aligned : '0;
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized and directed accesses against a word-level memory
// image plus a line-presence model of the cache.
module tb_data_cache;
    localparam int ML = 2;

    logic             clk = 0, rstn = 0;
    logic             cpu_read = 0, cpu_write = 0;
    logic [2:0]       funct3 = 0;
    logic [31:0]      cpu_addr = 0, cpu_wdata = 0;
    logic [31:0]      cpu_rdata;
    logic             stall, mem_ReadEn, mem_WriteEn;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_Addr, mem_WriteData;
    logic [3:0][31:0] mem_data;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    bit          ref_valid [0:15];
    int          ref_tag   [0:15];
    int          total = 0, bad = 0, wr_cycles = 0, rd_cycles = 0;

    data_cache #(.DATA_WIDTH(32), .LINE_SIZE(4), .NUM_LINES(16), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rstn(rstn), .cpu_read(cpu_read), .cpu_write(cpu_write), .funct3(funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_ReadEn(mem_ReadEn), .mem_WriteEn(mem_WriteEn), .mem_funct3(mem_funct3),
        .mem_Addr(mem_Addr), .mem_WriteData(mem_WriteData), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [2:0] f3);
        int b = int'(w & 32'hFF), h = int'(w & 32'hFFFF);
        case (f3)
            3'b000:  return 32'(b >= 128 ? b - 256 : b);
            3'b100:  return 32'(b);
            3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
            3'b101:  return 32'(h);
            3'b010:  return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] st_val(input logic [31:0] old, input logic [31:0] d, input logic [2:0] f3);
        if (f3 == 3'b000) return (old & ~32'hFF) | (d & 32'hFF);
        if (f3 == 3'b001) return (old & ~32'hFFFF) | (d & 32'hFFFF);
        return d;
    endfunction

    always_comb
        for (int i = 0; i < 4; i++) mem_data[i] = mem[(int'(mem_Addr[9:0]) & ~3) + i];

    always @(posedge clk) begin
        if (mem_ReadEn) rd_cycles++;
        if (mem_WriteEn) begin
            wr_cycles++;
            mem[mem_Addr[9:0]] = st_val(mem[mem_Addr[9:0]], mem_WriteData, mem_funct3);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input int a, input logic [31:0] wd);
        int  line = (a / 4) % 16, tg = a / 64, n = 0, wr0 = wr_cycles, rd0 = rd_cycles;
        bit  st = wr, ld = rd && !wr;
        bit  hit = ref_valid[line] && ref_tag[line] == tg;
        int  exp_stall = st ? 1 : (ld && !hit) ? ML + 1 : 0;
        @(negedge clk);
        cpu_read = rd; cpu_write = wr; funct3 = f3; cpu_addr = 32'(a); cpu_wdata = wd;
        #1;
        while (stall && n < 20) begin
            check("rdata_in_stall", cpu_rdata, 0);
            if (mem_ReadEn) check("refill_addr", mem_Addr, 32'(a & ~3));
            @(negedge clk);
            #1;
            n++;
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        if (st) begin
            check("we", 32'(mem_WriteEn), 1);
            check("w_addr", mem_Addr, 32'(a));
            check("w_funct3", 32'(mem_funct3), 32'(f3));
            check("w_data", mem_WriteData, wd);
            ref_mem[a] = st_val(ref_mem[a], wd, f3);
        end else if (ld) begin
            check("rdata", cpu_rdata, ld_val(ref_mem[a], f3));
            if (!hit) begin
                ref_valid[line] = 1;
                ref_tag[line] = tg;
            end
        end else begin
            check("rdata_idle", cpu_rdata, 0);
        end
        @(negedge clk);
        cpu_read = 0; cpu_write = 0;
        #1;
        check("we_pulses", 32'(wr_cycles - wr0), 32'(st));
        check("refill_cycles", 32'(rd_cycles - rd0), 32'((ld && !hit) ? ML : 0));
        check("we_off", 32'(mem_WriteEn), 0);
        if (st) check("mem_writethrough", mem[a], ref_mem[a]);
    endtask

    initial begin
        int r, a;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[6] = 18; mem[7] = 32'hA5214AAB; mem[8] = 25; mem[16] = 11;
        mem[59] = 32'hD494A2FA; mem[336] = 12414;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 16; i++) ref_valid[i] = 0;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_readen", 32'(mem_ReadEn), 0);
        check("rst_writeen", 32'(mem_WriteEn), 0);
        check("rst_rdata", cpu_rdata, 0);
        cpu_read = 1; cpu_addr = 7; funct3 = 3'b010;
        #1;
        check("rst_req_stall", 32'(stall), 0);
        cpu_read = 0;
        repeat (2) @(negedge clk);
        rstn = 1;

        access(1, 0, 3'b010, 7, 0);
        access(1, 0, 3'b010, 6, 0);
        access(1, 0, 3'b000, 7, 0);
        access(1, 0, 3'b100, 7, 0);
        access(1, 0, 3'b001, 59, 0);
        access(1, 0, 3'b101, 59, 0);
        access(1, 0, 3'b011, 6, 0);
        access(1, 0, 3'b010, 16, 0);
        access(1, 0, 3'b010, 336, 0);
        access(1, 0, 3'b010, 16, 0);
        access(1, 0, 3'b010, 8, 0);
        access(0, 1, 3'b000, 8, 32'h123456FF);
        access(1, 0, 3'b010, 8, 0);
        check("sb_merge", ref_mem[8], 32'h000000FF);
        access(1, 1, 3'b001, 9, 32'hCAFEBEEF);
        access(1, 0, 3'b010, 9, 0);
        access(0, 1, 3'b010, 500, 32'h0BADF00D);
        access(1, 0, 3'b010, 500, 0);

        @(negedge clk);
        cpu_read = 1; funct3 = 3'b010; cpu_addr = 40;
        repeat (2) @(negedge clk);
        check("refill_before_rst", 32'(mem_ReadEn), 1);
        rstn = 0;
        #1;
        check("rst_mid_stall", 32'(stall), 0);
        check("rst_mid_readen", 32'(mem_ReadEn), 0);
        check("rst_mid_rdata", cpu_rdata, 0);
        @(negedge clk);
        cpu_read = 0; rstn = 1;
        for (int i = 0; i < 16; i++) ref_valid[i] = 0;
        access(1, 0, 3'b010, 40, 0);

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 10);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 95);
            access(r < 6 || r == 9, r >= 6 && r <= 9, 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
